oam_dma_ctrl: RTL and testbench

- OAM DMA controller and bus arbiter for register $FF46.
- A CPU write of the source page starts a 160-byte copy from page<<8 into OAM at $FE00-$FE9F.
- Drives the shared memory read port (cart/VRAM/IRAM muxes in the top level) and the OAM write port.
- Tells the top level when CPU bus accesses must be blocked, i.e. every address except HRAM $FF80-$FFFE.

---
 rtl/oam_dma_ctrl.sv | 88 ++++++++
 tb/tb_oam_dma_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: $FF46 OAM DMA engine that copies one source page into OAM and arbitrates the CPU bus.
module oam_dma_ctrl #(
    parameter int START_DELAY = 4,
    parameter int BYTE_CYCLES = 4,
    parameter int NUM_BYTES   = 160
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_do,
    output logic        sel_dma,
    output logic [7:0]  reg_do,
    output logic        dma_active,
    output logic        cpu_block,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    input  logic [7:0]  dma_data,
    output logic        oam_wr,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_di
);
    localparam int PW = BYTE_CYCLES > 1 ? $clog2(BYTE_CYCLES) : 1;
    localparam int CW = $clog2(START_DELAY + 1);

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t        state;
    logic [7:0]    src_reg;
    logic [7:0]    idx;
    logic [7:0]    page;
    logic [PW-1:0] phase;
    logic [CW-1:0] cnt;
    logic          trig;
    logic          last_phase;
    logic          last_byte;

    // Outputs decode directly from registered state, so they freeze with ce=0 and clear instantly on reset.
    assign sel_dma    = cpu_addr == 16'hFF46;
    assign trig       = ce && cpu_wr && sel_dma;
    assign reg_do     = src_reg;
    assign page       = src_reg >= 8'hE0 ? src_reg - 8'h20 : src_reg;
    assign last_phase = phase == PW'(BYTE_CYCLES - 1);
    assign last_byte  = idx == 8'(NUM_BYTES - 1);
    assign dma_active = state != IDLE;
    assign dma_rd     = state == XFER;
    assign dma_addr   = dma_rd ? {page, idx} : 16'h0000;
    assign cpu_block  = dma_rd && !(cpu_addr >= 16'hFF80 && cpu_addr <= 16'hFFFE);
    assign oam_wr     = ce && dma_rd && last_phase;
    assign oam_addr   = idx;
    assign oam_di     = dma_data;

    // Sequencer: start delay, then per-byte phase/index stepping; a fresh trigger always restarts from START.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state   <= IDLE;
            src_reg <= 8'hFF;
            idx     <= '0;
            phase   <= '0;
            cnt     <= '0;
        end else if (ce) begin
            if (state == START) begin
                if (cnt == CW'(START_DELAY - 1)) begin
                    state <= XFER;
                    cnt   <= '0;
                    idx   <= '0;
                    phase <= '0;
                end else
                    cnt <= cnt + CW'(1);
            end else if (state == XFER) begin
                if (last_phase) begin
                    phase <= '0;
                    idx   <= last_byte ? 8'd0 : idx + 8'd1;
                    if (last_byte)
                        state <= IDLE;
                end else
                    phase <= phase + PW'(1);
            end
            if (trig) begin
                src_reg <= cpu_do;
                state   <= START;
                cnt     <= '0;
                idx     <= '0;
                phase   <= '0;
            end
        end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench for the OAM DMA controller.
module tb_oam_dma_ctrl;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        ce = 1;
    logic [15:0] cpu_addr = 16'h0000;
    logic        cpu_wr = 0;
    logic [7:0]  cpu_do = 8'h00;
    logic        sel_dma;
    logic [7:0]  reg_do;
    logic        dma_active;
    logic        cpu_block;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data = 8'h00;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_di;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  i;
        logic [7:0]  d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mem [0:65535];
    logic [7:0] oam [0:159];
    int         checks = 0;
    int         failures = 0;
    int         n;

    oam_dma_ctrl dut (
        .clk(clk), .reset_n(reset_n), .ce(ce), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
        .cpu_do(cpu_do), .sel_dma(sel_dma), .reg_do(reg_do), .dma_active(dma_active),
        .cpu_block(cpu_block), .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_data(dma_data),
        .oam_wr(oam_wr), .oam_addr(oam_addr), .oam_di(oam_di)
    );

    always #5 clk = ~clk;

    // Memory model with one clock of read latency.
    always @(posedge clk) dma_data <= mem[dma_addr];

    // Monitor: every OAM write pops the next expected byte.
    initial forever begin
        @(negedge clk);
        if (reset_n && !ce) begin
            checks++;
            if (oam_wr !== 1'b0) begin
                failures++;
                $display("FAIL oam_wr_ce0: got %b expected 0", oam_wr);
            end
        end
        if (reset_n && oam_wr === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: idx %h data %h addr %h, none expected", oam_addr, oam_di, dma_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (oam_addr !== e.i || oam_di !== e.d || dma_addr !== e.a) begin
                    failures++;
                    $display("FAIL oam_write: got idx %h data %h addr %h expected idx %h data %h addr %h",
                             oam_addr, oam_di, dma_addr, e.i, e.d, e.a);
                end
                oam[oam_addr] = oam_di;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_page(input logic [7:0] pg, input int from, input int to);
        for (int i = from; i <= to; i++)
            exp_q.push_back('{{pg, 8'(i)}, 8'(i), mem[{pg, 8'(i)}]});
    endtask

    task automatic wr_ff46(input logic [7:0] v);
        cpu_addr = 16'hFF46;
        cpu_do   = v;
        cpu_wr   = 1;
        @(posedge clk);
        #1;
        cpu_wr   = 0;
        cpu_addr = 16'h0000;
    endtask

    task automatic measure(input bit tog, output int cnt);
        cnt = 0;
        while (dma_active && cnt < 3000) begin
            if (tog) ce = ~ce;
            @(posedge clk);
            #1;
            cnt++;
        end
        ce = 1;
    endtask

    task automatic arb(input logic [15:0] a, input logic exp);
        cpu_addr = a;
        #1;
        check($sformatf("cpu_block_%h", a), 16'(cpu_block), 16'(exp));
    endtask

    task automatic oam_check(input int kind);
        for (int i = 0; i < 160; i++) begin
            logic [7:0] e;
            e = kind == 0 ? 8'(i) ^ 8'h5A : ~8'(i);
            check($sformatf("oam_%0d", i), 16'(oam[i]), 16'(e));
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) begin
            mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
            mem[16'hC200 + i] = 8'(i) + 8'h03;
            mem[16'h8000 + i] = ~8'(i);
        end
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_reg_do", 16'(reg_do), 16'hFF);
        check("rst_active", 16'(dma_active), 0);
        check("rst_dma_rd", 16'(dma_rd), 0);
        check("rst_dma_addr", dma_addr, 16'h0000);
        check("rst_oam_wr", 16'(oam_wr), 0);
        check("rst_oam_addr", 16'(oam_addr), 0);
        check("rst_cpu_block", 16'(cpu_block), 0);
        reset_n = 1;
        @(posedge clk);
        #1;

        // Abort a running transfer with asynchronous reset.
        push_page(8'hC1, 0, 9);
        wr_ff46(8'hC1);
        check("trig_active", 16'(dma_active), 1);
        check("trig_reg_do", 16'(reg_do), 16'hC1);
        repeat (45) @(posedge clk);
        #1;
        check("abort_pre_rd", 16'(dma_rd), 1);
        reset_n = 0;
        #1;
        check("abort_reg_do", 16'(reg_do), 16'hFF);
        check("abort_active", 16'(dma_active), 0);
        check("abort_dma_rd", 16'(dma_rd), 0);
        check("abort_oam_wr", 16'(oam_wr), 0);
        check("abort_queue", 16'(exp_q.size()), 0);
        @(posedge clk);
        #1;
        reset_n = 1;
        @(posedge clk);
        #1;

        // Basic copy from $C100.
        push_page(8'hC1, 0, 159);
        wr_ff46(8'hC1);
        measure(0, n);
        check("basic_len", 16'(n), 16'd644);
        check("basic_queue", 16'(exp_q.size()), 0);
        oam_check(0);

        // Echo page plus arbitration.
        push_page(8'hC2, 0, 159);
        wr_ff46(8'hE2);
        check("echo_reg_do", 16'(reg_do), 16'hE2);
        arb(16'hC000, 0);
        check("sel_dma_c000", 16'(sel_dma), 0);
        repeat (4) @(posedge clk);
        #1;
        check("echo_dma_rd", 16'(dma_rd), 1);
        check("echo_first_addr", dma_addr, 16'hC200);
        arb(16'hC000, 1);
        arb(16'hFF80, 0);
        arb(16'hFFFE, 0);
        arb(16'hFF46, 1);
        check("sel_dma_ff46", 16'(sel_dma), 1);
        arb(16'hFF7F, 1);
        arb(16'hFFFF, 1);
        cpu_addr = 16'h0000;
        measure(0, n);
        check("echo_done", 16'(dma_active), 0);
        check("echo_queue", 16'(exp_q.size()), 0);

        // Clock enable toggling every clock.
        push_page(8'hC1, 0, 159);
        wr_ff46(8'hC1);
        measure(1, n);
        check("ce_len", 16'(n), 16'd1288);
        check("ce_queue", 16'(exp_q.size()), 0);
        oam_check(0);

        // Restart mid-transfer at idx 50 phase 1 with VRAM page $80.
        push_page(8'hC1, 0, 49);
        push_page(8'h80, 0, 159);
        wr_ff46(8'hC1);
        repeat (205) @(posedge clk);
        #1;
        wr_ff46(8'h80);
        check("restart_reg_do", 16'(reg_do), 16'h80);
        check("restart_active", 16'(dma_active), 1);
        check("restart_start_rd", 16'(dma_rd), 0);
        repeat (4) @(posedge clk);
        #1;
        check("restart_addr", dma_addr, 16'h8000);
        measure(0, n);
        check("restart_len", 16'(n), 16'd640);
        check("restart_queue", 16'(exp_q.size()), 0);
        oam_check(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
